// File: rtl/rr_resource_arbiter_pkg.sv
// Shared types and helpers for the round-robin resource arbiter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package rr_resource_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Bits needed to encode an index in the range 0..count-1 (at least one bit).
    function automatic int count2width(input int count);
        if (count <= 2) begin
            return 1;
        end
        return $clog2(count);
    endfunction

endpackage

// File: rtl/rr_resource_arbiter_vector2index.sv
// Priority encoder: reports the lowest set bit of a vector and whether any bit is set.
// Latency: combinational.
// Backpressure: none; purely combinational.
module rr_resource_arbiter_vector2index #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] vector_in,
    output logic [IDX_W-1:0] index_out,
    output logic             contains_valid_index_out
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index_out                = '0;
        contains_valid_index_out = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vector_in[i]) begin
                index_out                = IDX_W'(i);
                contains_valid_index_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter granting one shared resource to NUM_REQ requesters until release/withdraw/timeout.
// Latency: grant registered one cycle after a request is seen in IDLE; one idle cycle between grants.
// Backpressure: no preemption; other requests wait by level until the owner lets go.
module rr_resource_arbiter
    import rr_resource_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MAX_HOLD       = 0,
    parameter int HOLD_CNT_WIDTH = 16,
    localparam int IDX_W         = count2width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               release_in,
    output logic               grant_valid_out,
    output logic [NUM_REQ-1:0] grant_onehot_out,
    output logic [IDX_W-1:0]   grant_index_out,
    output logic               timeout_out
);

    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_CNT_WIDTH'(MAX_HOLD - 1);

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_REQ-1:0]        onehot_q, onehot_d;
    logic                      valid_q, valid_d;
    logic                      timeout_q, timeout_d;
    logic [HOLD_CNT_WIDTH-1:0] hold_q, hold_d;

    logic [NUM_REQ-1:0] masked_req;
    logic [IDX_W-1:0]   masked_idx, raw_idx, win_idx;
    logic               masked_vld, raw_vld;
    logic               rel_norm, rel_force;

    // Only requesters strictly above the last winner are eligible in the first pass.
    always_comb begin
        masked_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked_req[i] = req_in[i] && (IDX_W'(i) > ptr_q);
        end
    end

    rr_resource_arbiter_vector2index #(
        .WIDTH (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_enc_masked (
        .vector_in                (masked_req),
        .index_out                (masked_idx),
        .contains_valid_index_out (masked_vld)
    );

    rr_resource_arbiter_vector2index #(
        .WIDTH (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_enc_raw (
        .vector_in                (req_in),
        .index_out                (raw_idx),
        .contains_valid_index_out (raw_vld)
    );

    assign win_idx = masked_vld ? masked_idx : raw_idx;

    // A voluntary release (release or withdraw) wins over a simultaneous timeout.
    assign rel_norm  = release_in || !req_in[idx_q];
    assign rel_force = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    // State and output registers; pointer resets so requester 0 has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            idx_q     <= '0;
            onehot_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state: IDLE always lasts at least one cycle, acting as bus turnaround.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (raw_vld) state_d = ST_GRANT;
            ST_GRANT: if (rel_norm || rel_force) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        onehot_d  = '0;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (raw_vld) begin
                    valid_d  = 1'b1;
                    idx_d    = win_idx;
                    onehot_d = NUM_REQ'(1) << win_idx;
                    ptr_d    = win_idx;
                    hold_d   = '0;
                end
            end
            ST_GRANT: begin
                if (rel_norm || rel_force) begin
                    timeout_d = rel_force && !rel_norm;
                end else begin
                    valid_d  = 1'b1;
                    onehot_d = onehot_q;
                    if (hold_q != '1) begin
                        hold_d = hold_q + HOLD_CNT_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign grant_valid_out  = valid_q;
    assign grant_onehot_out = onehot_q;
    assign grant_index_out  = idx_q;
    assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Scoreboard bench for rr_resource_arbiter: a cycle-level reference model predicts every output.
// Latency: expectations are queued at drive time and popped one cycle later by the monitor.
// Backpressure: n/a.
module tb_rr_resource_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic       v;
        logic [3:0] oh;
        logic [1:0] idx;
        logic       to;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req_in;
    logic       release_in;
    logic       grant_valid_out;
    logic [3:0] grant_onehot_out;
    logic [1:0] grant_index_out;
    logic       timeout_out;

    int tests  = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Reference model state: owner (-1 = nobody), last winner, cycles held so far.
    int   m_owner = -1;
    int   m_ptr   = N - 1;
    int   m_held  = 0;
    int   m_idx   = 0;
    bit   m_to    = 0;

    rr_resource_arbiter #(
        .NUM_REQ        (N),
        .MAX_HOLD       (MAX_HOLD),
        .HOLD_CNT_WIDTH (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_in           (req_in),
        .release_in       (release_in),
        .grant_valid_out  (grant_valid_out),
        .grant_onehot_out (grant_onehot_out),
        .grant_index_out  (grant_index_out),
        .timeout_out      (timeout_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one clock edge with the given inputs and queue the outputs it predicts.
    task automatic model_step(input bit rst, input bit [3:0] req, input bit rel);
        exp_t e;
        if (rst) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_held  = 0;
            m_idx   = 0;
            m_to    = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            if (req != 4'b0) begin
                bit found = 0;
                for (int k = 1; k <= N; k++) begin
                    int c = (m_ptr + k) % N;
                    if (!found && req[c]) begin
                        found   = 1;
                        m_owner = c;
                    end
                end
                m_ptr  = m_owner;
                m_idx  = m_owner;
                m_held = 1;
            end
        end else begin
            bit norm   = rel || !req[m_owner];
            bit forced = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (norm || forced) begin
                m_to    = forced && !norm;
                m_owner = -1;
            end else begin
                m_held++;
                m_to = 0;
            end
        end
        e.v   = (m_owner >= 0);
        e.oh  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        e.idx = 2'(m_idx);
        e.to  = m_to;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit [3:0] req, input bit rel);
        reset      = rst;
        req_in     = req;
        release_in = rel;
        model_step(rst, req, rel);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 4'b0, 1'b0);
        step(1'b1, 4'b0, 1'b0);
    endtask

    // Monitor: every edge presents a new output word; compare it with the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: output cycle at %0t with no prediction queued", $time);
            end else begin
                exp_t e;
                exp_t got;
                e   = exp_q.pop_front();
                got = '{v: grant_valid_out, oh: grant_onehot_out, idx: grant_index_out, to: timeout_out};
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: actual v=%b oh=%b idx=%0d to=%b, required v=%b oh=%b idx=%0d to=%b",
                             $time, got.v, got.oh, got.idx, got.to, e.v, e.oh, e.idx, e.to);
                end
            end
            tests++;
            if ($countones(grant_onehot_out) > 1 ||
                (grant_valid_out && grant_onehot_out !== (4'b1 << grant_index_out))) begin
                errors++;
                $display("FAIL onehot_consistency @%0t: actual oh=%b idx=%0d v=%b, required single bit at idx",
                         $time, grant_onehot_out, grant_index_out, grant_valid_out);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        req_in     = 4'b0;
        release_in = 1'b0;

        // Two requesters alternate through release pulses.
        do_reset();
        step(1'b0, 4'b0101, 1'b0);
        step(1'b0, 4'b0101, 1'b1);
        step(1'b0, 4'b0101, 1'b0);
        step(1'b0, 4'b0101, 1'b1);
        step(1'b0, 4'b0101, 1'b0);
        step(1'b0, 4'b0101, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // All four requesting: rotation 0,1,2,3,0 with one idle cycle between grants.
        do_reset();
        repeat (5) begin
            step(1'b0, 4'b1111, 1'b0);
            step(1'b0, 4'b1111, 1'b1);
        end

        // No release: idx0 times out after MAX_HOLD cycles, then idx1 is granted.
        do_reset();
        repeat (2 * MAX_HOLD + 4) step(1'b0, 4'b0011, 1'b0);

        // Owner idx1 withdraws mid-grant; next grant goes to the lowest index above 1.
        do_reset();
        step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b1010, 1'b0);
        step(1'b0, 4'b1101, 1'b0);
        step(1'b0, 4'b1101, 1'b0);
        step(1'b0, 4'b1101, 1'b0);

        // Reset during a grant to idx3, then idx0 wins against idx3.
        do_reset();
        step(1'b0, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        step(1'b1, 4'b1001, 1'b0);
        step(1'b0, 4'b1001, 1'b0);
        step(1'b0, 4'b1001, 1'b0);

        // Release lands in the same cycle as the timeout would: no timeout pulse.
        do_reset();
        step(1'b0, 4'b0001, 1'b0);
        while (m_owner >= 0 && m_held < MAX_HOLD) step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);

        // Randomized traffic with occasional releases and resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit [3:0] r;
            bit       rl;
            bit       rs;
            r  = 4'($urandom_range(0, 15));
            rl = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 63) == 0);
            step(rs, r, rl);
        end

        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d predictions left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
